// File: rtl/adder_arbiter.sv
// Two-port round-robin front end for a single 4-bit top_adder: operands and result are registered.
// Optional grant/overflow statistics counters are built when ADDER_ARB_STATS_EN is defined.

module top_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] OutSum,
  output logic       overflow
);
  assign {overflow, OutSum} = {1'b0, A} + {1'b0, B};
endmodule

module adder_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  output logic             RespValid,
  input  logic             RespReady,
  output logic             RespId,
  output logic [WIDTH-1:0] RespSum,
  output logic             RespOverflow,
`ifdef ADDER_ARB_STATS_EN
  output logic [CNT_W-1:0] Gnt0Count,
  output logic [CNT_W-1:0] Gnt1Count,
  output logic [CNT_W-1:0] OvfCount,
`endif
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where Valid and Ready are both 1.
  // Requesters hold Valid/operands until Ready; the response holds until RespReady.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             rr_ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             gnt0;
  logic             gnt1;
  logic             hs0;
  logic             hs1;
  logic             resp_hs;

  top_adder u_adder (
    .A        (op_a),
    .B        (op_b),
    .OutSum   (add_sum),
    .overflow (add_ovf)
  );

  // A lone requester always wins; on a tie the pointer picks (0 favours Req0).
  assign gnt0 = Req0Valid & (~Req1Valid | ~rr_ptr);
  assign gnt1 = Req1Valid & (~Req0Valid | rr_ptr);

  assign Req0Ready = (state == IDLE) & ~rst & gnt0;
  assign Req1Ready = (state == IDLE) & ~rst & gnt1;
  assign hs0       = Req0Valid & Req0Ready;
  assign hs1       = Req1Valid & Req1Ready;
  assign RespValid = (state == RESP);
  assign resp_hs   = RespValid & RespReady;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= 1'b0;
      RespId       <= 1'b0;
      RespSum      <= '0;
      RespOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs0) begin
            op_a   <= Req0A;
            op_b   <= Req0B;
            op_id  <= 1'b0;
            rr_ptr <= 1'b1;
            state  <= CALC;
          end else if (hs1) begin
            op_a   <= Req1A;
            op_b   <= Req1B;
            op_id  <= 1'b1;
            rr_ptr <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          RespId       <= op_id;
          RespSum      <= add_sum;
          RespOverflow <= add_ovf;
          state        <= RESP;
        end
        RESP: begin
          if (resp_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Gnt0Count <= '0;
      Gnt1Count <= '0;
      OvfCount  <= '0;
    end else begin
      if (hs0 && Gnt0Count != '1) Gnt0Count <= Gnt0Count + 1'b1;
      if (hs1 && Gnt1Count != '1) Gnt1Count <= Gnt1Count + 1'b1;
      if (resp_hs && RespOverflow && OvfCount != '1) OvfCount <= OvfCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arbitration, latency, backpressure, reset and throughput.
// Define ADDER_ARB_STATS_EN for both files to also cover the statistics counters.

module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       Req0Valid, Req1Valid, RespReady;
  logic       Req0Ready, Req1Ready, RespValid, RespId, RespOverflow;
  logic [3:0] Req0A, Req0B, Req1A, Req1B, RespSum;
  logic [1:0] dbg_state;
`ifdef ADDER_ARB_STATS_EN
  logic [7:0] Gnt0Count, Gnt1Count, OvfCount;
`endif

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
    .RespSum(RespSum), .RespOverflow(RespOverflow),
`ifdef ADDER_ARB_STATS_EN
    .Gnt0Count(Gnt0Count), .Gnt1Count(Gnt1Count), .OvfCount(OvfCount),
`endif
    .dbg_state(dbg_state)
  );

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Req0Valid = 1'b0; Req1Valid = 1'b0; RespReady = 1'b0;
    Req0A = 4'd0; Req0B = 4'd0; Req1A = 4'd0; Req1B = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    step(); step();
    checks++; if (RespValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", RespValid); end
    checks++; if (RespId !== 1'b0) begin failures++; $display("FAIL rst_id got=%b exp=0", RespId); end
    checks++; if (RespSum !== 4'd0) begin failures++; $display("FAIL rst_sum got=%b exp=0000", RespSum); end
    checks++; if (RespOverflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", RespOverflow); end
    checks++; if ({Req0Ready, Req1Ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {Req0Ready, Req1Ready}); end
    idle_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_req0_only();
    Req0Valid = 1'b1; Req0A = 4'b0100; Req0B = 4'b0110; RespReady = 1'b1;
    #1;
    checks++; if ({Req0Ready, Req1Ready} !== 2'b10) begin failures++; $display("FAIL t1_ready got=%b exp=10", {Req0Ready, Req1Ready}); end
    step();
    Req0Valid = 1'b0;
    checks++; if (RespValid !== 1'b0) begin failures++; $display("FAIL t1_calc_valid got=%b exp=0", RespValid); end
    step();
    checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'b1_0_0_1010) begin failures++; $display("FAIL t1_resp got=%b exp=1001010", {RespValid, RespId, RespOverflow, RespSum}); end
    step();
    checks++; if (RespValid !== 1'b0) begin failures++; $display("FAIL t1_after got=%b exp=0", RespValid); end
    idle_inputs();
  endtask

  task automatic test_both_valid();
    do_reset();
    Req0Valid = 1'b1; Req0A = 4'b0101; Req0B = 4'b0111;
    Req1Valid = 1'b1; Req1A = 4'b1111; Req1B = 4'b0001;
    RespReady = 1'b1;
    #1;
    checks++; if ({Req0Ready, Req1Ready} !== 2'b10) begin failures++; $display("FAIL t2_first got=%b exp=10", {Req0Ready, Req1Ready}); end
    step();
    Req0Valid = 1'b0;
    checks++; if (Req1Ready !== 1'b0) begin failures++; $display("FAIL t2_calc_ready got=%b exp=0", Req1Ready); end
    step();
    checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'b1_0_0_1100) begin failures++; $display("FAIL t2_resp0 got=%b exp=1001100", {RespValid, RespId, RespOverflow, RespSum}); end
    checks++; if (Req1Ready !== 1'b0) begin failures++; $display("FAIL t2_resp_ready got=%b exp=0", Req1Ready); end
    step();
    Req0Valid = 1'b1;
    #1;
    checks++; if ({Req0Ready, Req1Ready} !== 2'b01) begin failures++; $display("FAIL t2_second got=%b exp=01", {Req0Ready, Req1Ready}); end
    step();
    Req1Valid = 1'b0;
    step();
    checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'b1_1_1_0000) begin failures++; $display("FAIL t2_resp1 got=%b exp=1110000", {RespValid, RespId, RespOverflow, RespSum}); end
    step();
    checks++; if ({Req0Ready, Req1Ready} !== 2'b10) begin failures++; $display("FAIL t2_third got=%b exp=10", {Req0Ready, Req1Ready}); end
    step();
    Req0Valid = 1'b0;
    step();
    checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'b1_0_0_1100) begin failures++; $display("FAIL t2_resp2 got=%b exp=1001100", {RespValid, RespId, RespOverflow, RespSum}); end
    step();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    // Pointer is 1 here (last grant went to Req0).
    Req0Valid = 1'b1; Req0A = 4'b1001; Req0B = 4'b1000; RespReady = 1'b0;
    #1;
    checks++; if (Req0Ready !== 1'b1) begin failures++; $display("FAIL t3_accept got=%b exp=1", Req0Ready); end
    step();
    Req0Valid = 1'b0;
    step();
    Req0Valid = 1'b1; Req1Valid = 1'b1; Req1A = 4'b0011; Req1B = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'b1_0_1_0001) begin failures++; $display("FAIL t3_hold%0d got=%b exp=1010001", i, {RespValid, RespId, RespOverflow, RespSum}); end
      checks++; if ({Req0Ready, Req1Ready} !== 2'b00) begin failures++; $display("FAIL t3_ready%0d got=%b exp=00", i, {Req0Ready, Req1Ready}); end
      step();
    end
    RespReady = 1'b1;
    #1;
    checks++; if (RespValid !== 1'b1) begin failures++; $display("FAIL t3_last got=%b exp=1", RespValid); end
    step();
    checks++; if (RespValid !== 1'b0) begin failures++; $display("FAIL t3_consumed got=%b exp=0", RespValid); end
    checks++; if ({Req0Ready, Req1Ready} !== 2'b01) begin failures++; $display("FAIL t3_rr got=%b exp=01", {Req0Ready, Req1Ready}); end
    #1;
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_op();
    Req1Valid = 1'b1; Req1A = 4'b1010; Req1B = 4'b0111; RespReady = 1'b1;
    #1;
    checks++; if (Req1Ready !== 1'b1) begin failures++; $display("FAIL t4_accept got=%b exp=1", Req1Ready); end
    step();
    Req1Valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'd0) begin failures++; $display("FAIL t4_quiet%0d got=%b exp=0000000", i, {RespValid, RespId, RespOverflow, RespSum}); end
      step();
    end
    // Tie after reset: pointer must favour Req0.
    Req0Valid = 1'b1; Req0A = 4'b0101; Req0B = 4'b0111;
    Req1Valid = 1'b1; Req1A = 4'b0001; Req1B = 4'b0001;
    #1;
    checks++; if ({Req0Ready, Req1Ready} !== 2'b10) begin failures++; $display("FAIL t4_tie got=%b exp=10", {Req0Ready, Req1Ready}); end
    step();
    Req0Valid = 1'b0; Req1Valid = 1'b0; RespReady = 1'b0;
    step(); step();
    checks++; if ({RespValid, RespSum} !== 5'b1_1100) begin failures++; $display("FAIL t4_resp got=%b exp=11100", {RespValid, RespSum}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({RespValid, RespId, RespOverflow, RespSum} !== 7'd0) begin failures++; $display("FAIL t4_rst_resp got=%b exp=0000000", {RespValid, RespId, RespOverflow, RespSum}); end
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    #1;
    checks++; if ({Req0Ready, Req1Ready} !== 2'b10) begin failures++; $display("FAIL t4_ptr got=%b exp=10", {Req0Ready, Req1Ready}); end
    #1;
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    do_reset();
    Req1Valid = 1'b1; Req1A = 4'b1111; Req1B = 4'b0011; RespReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (Req1Ready !== (i % 3 == 0)) begin failures++; $display("FAIL t5_ready%0d got=%b exp=%b", i, Req1Ready, (i % 3 == 0)); end
      if (Req1Valid && Req1Ready) exp_q.push_back({1'b1, 1'b1, 4'b0010});
      if (RespValid && RespReady) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bx;
        checks++; if ({RespId, RespOverflow, RespSum} !== exp) begin failures++; $display("FAIL t5_resp%0d got=%b exp=%b", i, {RespId, RespOverflow, RespSum}, exp); end
      end
      step();
    end
    Req1Valid = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t5_drain got=%0d exp=0", exp_q.size()); end
    idle_inputs();
    step();
  endtask

`ifdef ADDER_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    RespReady = 1'b1;
    Req0Valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      Req0A = (i < 4) ? 4'b1111 : 4'b0001;
      Req0B = 4'b0001;
      step(); step(); step();
    end
    Req0Valid = 1'b0;
    step(); step(); step();
    checks++; if (Gnt0Count !== 8'd255) begin failures++; $display("FAIL t6_gnt0 got=%0d exp=255", Gnt0Count); end
    checks++; if (Gnt1Count !== 8'd0) begin failures++; $display("FAIL t6_gnt1 got=%0d exp=0", Gnt1Count); end
    checks++; if (OvfCount !== 8'd4) begin failures++; $display("FAIL t6_ovf got=%0d exp=4", OvfCount); end
    do_reset();
    checks++; if ({Gnt0Count, Gnt1Count, OvfCount} !== 24'd0) begin failures++; $display("FAIL t6_clear got=%h exp=0", {Gnt0Count, Gnt1Count, OvfCount}); end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_req0_only();
    test_both_valid();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
`ifdef ADDER_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
